m_bpred: RTL

- Parametrised branch predictor for the pipelined RV32I core: direct-mapped BTB with a 2-bit saturating direction counter per entry.
- Replaces the fixed 32-entry BTB and the hardwired taken-prediction PC in the fetch stage.
- Fetch stage looks up r_pc combinationally. The execute stage (P2) writes back resolved branch outcome, target and mispredict flag.
- Includes update and mispredict performance counters.

---
 rtl/m_bpred.sv | 113 +++++++++++
 1 files changed

// File: rtl/m_bpred.sv
`default_nettype none
// ============================================================================
// Module   : m_bpred
// Brief    : Direct-mapped BTB with 2-bit saturating direction counters,
//            asynchronous lookup, registered update, perf counters.
// Revision : 1.0
// ============================================================================
module m_bpred #(
   parameter int         ENTRIES  = 32,
   parameter int         CNT_W    = 32,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic [31:0]      w_pc,
   output logic             w_hit,
   output logic             w_pred_tkn,
   output logic [31:0]      w_ppc,
   input  logic             w_upd_v,
   input  logic [31:0]      w_upd_pc,
   input  logic             w_upd_tkn,
   input  logic [31:0]      w_upd_tgt,
   input  logic             w_upd_miss,
   output logic [CNT_W-1:0] r_n_upd,
   output logic [CNT_W-1:0] r_n_miss
);
   localparam int               IDX     = $clog2(ENTRIES);
   localparam int               TAG_W   = 30 - IDX;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic             valid   [ENTRIES];
   logic [TAG_W-1:0] tag_mem [ENTRIES];
   logic [31:0]      tgt_mem [ENTRIES];
   logic [1:0]       ctr_mem [ENTRIES];

   logic [IDX-1:0]   rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX-1:0]   up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [1:0]       ctr_cur;
   logic [1:0]       ctr_nxt;
   logic             alloc;
   logic             wr_ctr;
   logic             wr_tgt;
   logic             unused_low;

   // Byte offset bits never take part in indexing or tagging.
   assign unused_low = ^{w_pc[1:0], w_upd_pc[1:0]};

   assign rd_idx     = w_pc[IDX+1:2];
   assign rd_tag     = w_pc[31:IDX+2];
   assign w_hit      = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign w_pred_tkn = w_hit & ctr_mem[rd_idx][1];
   assign w_ppc      = w_hit ? tgt_mem[rd_idx] : 32'h0;

   assign up_idx  = w_upd_pc[IDX+1:2];
   assign up_tag  = w_upd_pc[31:IDX+2];
   assign up_hit  = valid[up_idx] && (tag_mem[up_idx] == up_tag);
   assign ctr_cur = ctr_mem[up_idx];

   always_comb begin
      ctr_nxt = ctr_cur;
      alloc   = 1'b0;
      wr_ctr  = 1'b0;
      wr_tgt  = 1'b0;
      if (w_upd_v) begin
         if (up_hit) begin
            wr_ctr = 1'b1;
            if (w_upd_tkn) begin
               wr_tgt = 1'b1;
               if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
            end else if (ctr_cur != 2'b00) begin
               ctr_nxt = ctr_cur - 2'd1;
            end
         end else if (w_upd_tkn) begin
            // Taken miss evicts whatever occupies the slot, starting weakly taken.
            alloc   = 1'b1;
            wr_ctr  = 1'b1;
            wr_tgt  = 1'b1;
            ctr_nxt = 2'b10;
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]   <= 1'b0;
            ctr_mem[i] <= INIT_CTR;
         end
         r_n_upd  <= '0;
         r_n_miss <= '0;
      end else begin
         if (alloc)  valid[up_idx]   <= 1'b1;
         if (wr_ctr) ctr_mem[up_idx] <= ctr_nxt;
         if (w_upd_v) begin
            r_n_upd <= r_n_upd + CNT_ONE;
            if (w_upd_miss) r_n_miss <= r_n_miss + CNT_ONE;
         end
      end
   end

   // Tag and target need no reset: an invalid slot never hits.
   always_ff @(posedge w_clk) begin
      if (!w_rst) begin
         if (alloc)  tag_mem[up_idx] <= up_tag;
         if (wr_tgt) tgt_mem[up_idx] <= w_upd_tgt;
      end
   end

endmodule
`default_nettype wire
